rv32m_div_unit: RTL

- Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Acts as the responder to the execute stage's divide request handshake.
- The execute stage raises div_start and holds its operands stable while it stalls; this block asserts div_ready for exactly one cycle with the result, which releases the stall.
- Sits inside the M-extension wrapper, alongside the multiplier.

---
 rtl/m_ext_pkg.sv | 17 +
 rtl/rv32m_div_step.sv | 23 ++
 rtl/rv32m_div_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/m_ext_pkg.sv
// Shared definitions for the M-extension blocks: op encodings, divider FSM states, XLEN.
package m_ext_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/rv32m_div_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract |divisor|.
module rv32m_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] r_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] d_i,
  output logic [XLEN-1:0] r_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] r_sh;
  logic          ge;

  // Shifted remainder kept at XLEN+1 bits so the compare/subtract never truncates.
  always_comb begin
    r_sh = {r_i, q_i[XLEN-1]};
    ge   = (r_sh >= {1'b0, d_i});
    r_o  = ge ? XLEN'(r_sh - {1'b0, d_i}) : r_sh[XLEN-1:0];
    q_o  = {q_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU; one restoring step per cycle.
module rv32m_div_unit
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = m_ext_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_dividend,
  input  logic [XLEN-1:0] div_divisor,
  input  logic            div_flush,
  output logic            div_ready,
  output logic [XLEN-1:0] div_result,
  output logic            div_busy
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            signed_q, signed_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed, a_neg, b_neg, ovf;
  logic [XLEN-1:0] a_abs, b_abs, step_r, step_q, q_fin, r_fin, done_val;

  rv32m_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .r_i(r_q),
    .q_i(q_q),
    .d_i(dvs_q),
    .r_o(step_r),
    .q_o(step_q)
  );

  // Operand conditioning, sign fix-up of the final result and output decode.
  always_comb begin
    is_signed  = ~div_op[0];
    a_neg      = is_signed & div_dividend[XLEN-1];
    b_neg      = is_signed & div_divisor[XLEN-1];
    a_abs      = a_neg ? (~div_dividend + 1'b1) : div_dividend;
    b_abs      = b_neg ? (~div_divisor + 1'b1) : div_divisor;
    ovf        = is_signed && (div_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (&div_divisor);
    q_fin      = (signed_q && q_neg_q) ? (~q_q + 1'b1) : q_q;
    r_fin      = (signed_q && r_neg_q) ? (~r_q + 1'b1) : r_q;
    done_val   = op_q[1] ? r_fin : q_fin;
    // A flush in the DONE cycle suppresses the pulse and leaves the result untouched.
    div_ready  = (state_q == DIV_DONE) && !div_flush;
    div_result = div_ready ? done_val : result_q;
    div_busy   = (state_q != DIV_IDLE);
  end

  // Next-state logic: acceptance and fast paths, iteration, completion, flush.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    r_d      = r_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (div_flush) begin
      state_d = DIV_IDLE;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (div_start) begin
            op_d     = div_op;
            cnt_d    = '0;
            q_neg_d  = 1'b0;
            r_neg_d  = 1'b0;
            signed_d = 1'b0;
            state_d  = DIV_DONE;
            if (div_divisor == '0) begin
              q_d = '1;
              r_d = div_dividend;
            end else if (ovf) begin
              q_d = {1'b1, {(XLEN-1){1'b0}}};
              r_d = '0;
            end else begin
              // The dividend magnitude is shifted out of q into r bit by bit.
              q_d      = a_abs;
              r_d      = '0;
              dvs_d    = b_abs;
              signed_d = is_signed;
              q_neg_d  = a_neg ^ b_neg;
              r_neg_d  = a_neg;
              state_d  = DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          r_d   = step_r;
          q_d   = step_q;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: begin
          result_d = done_val;
          state_d  = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      op_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      r_q      <= r_d;
      q_q      <= q_d;
      dvs_q    <= dvs_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
